data_memory_responder: RTL and testbench

Memory-side responder for the processor's data port. It serves scalar word loads and stores with byte enables on a single-port, word-wide synchronous RAM. It also serves 256-bit vector loads and stores by splitting each one into sequential word beats, and it drives `Busy` to the hazard unit while a vector transfer is in flight. It sits between the processor's memory stage and the data RAM.

---
 rtl/data_memory_responder.sv | 121 ++++++++++++
 tb/tb_data_memory_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: scalar byte-enabled and beat-split vector access to a word-wide single-port RAM
module data_memory_responder #(
  parameter int N = 32,
  parameter int V = 256,
  parameter int DEPTH = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] AddressData,
  input  logic [N-1:0] ByteenaData,
  input  logic [N-1:0] WriteData,
  input  logic         RdenData,
  input  logic         WrenData,
  output logic [N-1:0] ReadData,
  input  logic         VecRden,
  input  logic         VecWren,
  input  logic [V-1:0] VecWriteData,
  output logic [V-1:0] VecReadData,
  output logic         VecValid,
  output logic         Busy
);
  localparam int BEATS = V / N;
  localparam int BW = $clog2(BEATS);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = N / 8;
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [AW-1:0] base_q, base_d, idx, ram_addr;
  logic vec_wr_q, vec_wr_d, vvalid_q, vvalid_d;
  logic [V-1:0] vwd_q, vwd_d, vrd_q, vrd_d;
  logic [V-N-1:0] vbuf_q, vbuf_d;
  logic [N-1:0] mem [DEPTH];
  logic [N-1:0] ram_q, rdata_q, ram_wdata;
  logic [NB-1:0] ram_be;
  logic ram_we, ram_re, scalar_re;
  logic unused;
  assign idx = AddressData[AW+1:2];
  assign unused = ^{AddressData[N-1:AW+2], AddressData[1:0], ByteenaData[N-1:NB]};
  assign Busy = (state_q != IDLE) || (en && (VecRden || VecWren));
  assign ReadData = rdata_q;
  assign VecReadData = vrd_q;
  assign VecValid = vvalid_q;
  // Write data drains from the bottom lane; read lanes shift in from the top so lane 0 ends lowest.
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    base_d = base_q;
    vec_wr_d = vec_wr_q;
    vwd_d = vwd_q;
    vbuf_d = vbuf_q;
    vrd_d = vrd_q;
    vvalid_d = vvalid_q;
    ram_addr = idx;
    ram_wdata = WriteData;
    ram_be = ByteenaData[NB-1:0];
    ram_we = 1'b0;
    ram_re = 1'b0;
    scalar_re = 1'b0;
    if (en) begin
      vvalid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (VecWren || VecRden) begin
            state_d = XFER;
            beat_d = '0;
            base_d = {idx[AW-1:BW], {BW{1'b0}}};
            vec_wr_d = VecWren;
            vwd_d = VecWriteData;
          end else begin
            ram_we = WrenData;
            scalar_re = !WrenData && RdenData;
          end
        end
        XFER: begin
          ram_addr = base_q + AW'(beat_q);
          ram_wdata = vwd_q[N-1:0];
          ram_be = '1;
          ram_we = vec_wr_q;
          ram_re = !vec_wr_q;
          vwd_d = {{N{1'b0}}, vwd_q[V-1:N]};
          vbuf_d = (!vec_wr_q && beat_q != '0) ? {ram_q, vbuf_q[V-N-1:N]} : vbuf_q;
          beat_d = beat_q + BW'(1);
          state_d = (beat_q == BW'(BEATS - 1)) ? (vec_wr_q ? IDLE : DRAIN) : XFER;
        end
        DRAIN: begin
          vrd_d = {ram_q, vbuf_q};
          vvalid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q <= '0;
      vrd_q <= '0;
      vvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      vrd_q <= vrd_d;
      vvalid_q <= vvalid_d;
    end
    base_q <= base_d;
    vec_wr_q <= vec_wr_d;
    vwd_q <= vwd_d;
    vbuf_q <= vbuf_d;
  end
  // Reset blocks RAM writes so an aborted vector write commits nothing in that cycle.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (scalar_re) rdata_q <= mem[ram_addr];
    if (ram_re) ram_q <= mem[ram_addr];
    for (int k = 0; k < NB; k++)
      if (!rst && ram_we && ram_be[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: transaction-level model with per-cycle compare plus directed literal checks
module tb_data_memory_responder;
  localparam int N = 32, V = 256, DEPTH = 1024, BEATS = V / N;
  logic clk = 1'b0, rst, en;
  logic [N-1:0] AddressData, ByteenaData, WriteData, ReadData;
  logic RdenData, WrenData, VecRden, VecWren, VecValid, Busy;
  logic [V-1:0] VecWriteData, VecReadData;
  int pass_cnt = 0, chk_cnt = 0;
  logic [N-1:0] m_mem [DEPTH];
  logic [N-1:0] m_rd = '0;
  logic [V-1:0] m_vec = '0, m_wdata = '0;
  logic m_valid = 1'b0, m_wr = 1'b0;
  int m_cnt = 0, m_base = 0;

  data_memory_responder dut (
    .clk(clk), .rst(rst), .en(en), .AddressData(AddressData), .ByteenaData(ByteenaData),
    .WriteData(WriteData), .RdenData(RdenData), .WrenData(WrenData), .ReadData(ReadData),
    .VecRden(VecRden), .VecWren(VecWren), .VecWriteData(VecWriteData),
    .VecReadData(VecReadData), .VecValid(VecValid), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [V-1:0] act, logic [V-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // m_cnt counts cycles since a vector accept: 1..8 are beats, 9 is the read drain cycle.
  always @(posedge clk) begin
    int w;
    w = int'(AddressData[11:2]);
    if (rst) begin
      m_cnt = 0; m_rd = '0; m_vec = '0; m_valid = 1'b0;
    end else if (en) begin
      m_valid = 1'b0;
      if (m_cnt == 0) begin
        if (VecWren || VecRden) begin
          m_wr = VecWren; m_base = w - w % BEATS; m_wdata = VecWriteData; m_cnt = 1;
        end else if (WrenData) begin
          for (int k = 0; k < 4; k++) if (ByteenaData[k]) m_mem[w][8*k +: 8] = WriteData[8*k +: 8];
        end else if (RdenData) m_rd = m_mem[w];
      end else begin
        if (m_wr) m_mem[(m_base + m_cnt - 1) % DEPTH] = m_wdata[N*(m_cnt-1) +: N];
        else if (m_cnt == BEATS + 1) begin
          for (int i = 0; i < BEATS; i++) m_vec[N*i +: N] = m_mem[(m_base + i) % DEPTH];
          m_valid = 1'b1;
        end
        m_cnt = (m_cnt == (m_wr ? BEATS : BEATS + 1)) ? 0 : m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", V'(Busy), V'((m_cnt != 0) || (en && (VecRden || VecWren))));
    chk("read_data", V'(ReadData), V'(m_rd));
    chk("vec_valid", V'(VecValid), V'(m_valid));
    chk("vec_read_data", VecReadData, m_vec);
  end

  task automatic step();
    @(negedge clk); #1;
  endtask
  task automatic swrite(int a, logic [N-1:0] d, logic [3:0] be);
    AddressData = N'(a); WriteData = d; ByteenaData = {28'b0, be}; WrenData = 1'b1;
    step(); WrenData = 1'b0;
  endtask
  task automatic sread(int a);
    AddressData = N'(a); RdenData = 1'b1;
    step(); RdenData = 1'b0;
  endtask
  task automatic vop(bit wr, int a, logic [V-1:0] d);
    AddressData = N'(a); VecWriteData = d; VecWren = wr; VecRden = !wr;
    step(); VecWren = 1'b0; VecRden = 1'b0;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!VecValid && n < 50) begin step(); n++; end
  endtask

  initial begin
    logic [V-1:0] vv, va, vw;
    int n;
    rst = 1'b1; en = 1'b1; AddressData = '0; ByteenaData = '0; WriteData = '0;
    RdenData = 1'b0; WrenData = 1'b0; VecRden = 1'b0; VecWren = 1'b0; VecWriteData = '0;
    step(); step(); rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) swrite(4 * i, $urandom, 4'hF);
    swrite(32'h40, 32'h11223344, 4'hF);
    swrite(32'h40, 32'hAABBCCDD, 4'h5);
    sread(32'h40);
    chk("byte_write", V'(ReadData), V'(32'h11BB33DD));
    for (int i = 0; i < BEATS; i++) begin vv[N*i +: N] = 32'h1000 + i; va[N*i +: N] = 32'h7000 + i; end
    AddressData = 32'h100; VecWriteData = vv; VecWren = 1'b1; n = 0;
    for (int c = 0; c < 20; c++) begin #2; if (Busy) n++; step(); VecWren = 1'b0; end
    chk("vec_wr_busy_cycles", V'(n), V'(9));
    vop(0, 32'h11C, '0);
    wait_valid(n);
    chk("vec_rd_latency", V'(n + 1), V'(10));
    chk("vec_rd_data", VecReadData, vv);
    sread(32'h10C);
    chk("scalar_after_vec", V'(ReadData), V'(32'h1003));
    swrite(0, 32'hC0FFEE00, 4'hF);
    swrite(32'hFFC, 32'h0BADF00D, 4'hF);
    vop(1, 32'hFE0, va);
    repeat (8) step();
    sread(0);
    chk("wrap_word0", V'(ReadData), V'(32'hC0FFEE00));
    sread(32'hFFC);
    chk("wrap_last", V'(ReadData), V'(32'h7007));
    sread(32'h40);
    AddressData = 32'h40; WriteData = 32'hFFFFFFFF; ByteenaData = 32'hF;
    RdenData = 1'b1; WrenData = 1'b1; VecRden = 1'b1;
    step(); RdenData = 1'b0; WrenData = 1'b0; VecRden = 1'b0;
    wait_valid(n);
    chk("conflict_readdata", V'(ReadData), V'(32'h11BB33DD));
    chk("conflict_lane0", V'(VecReadData[31:0]), V'(32'h11BB33DD));
    sread(32'h40);
    chk("conflict_ram", V'(ReadData), V'(32'h11BB33DD));
    swrite(32'h44, 32'h12345678, 4'hF);
    vw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    vop(1, 32'h300, vw);
    AddressData = 32'h44; WriteData = 32'hDEADBEEF; ByteenaData = 32'hF; WrenData = 1'b1;
    step(); WrenData = 1'b0;
    repeat (7) step();
    sread(32'h44);
    chk("xfer_write_ignored", V'(ReadData), V'(32'h12345678));
    vop(0, 32'h100, '0);
    repeat (3) step();
    en = 1'b0; repeat (3) step(); en = 1'b1;
    wait_valid(n);
    chk("stall_latency", V'(n + 7), V'(13));
    chk("stall_data", VecReadData, vv);
    for (int i = 0; i < BEATS; i++) begin
      swrite(32'h200 + 4 * i, 32'h5500 + i, 4'hF);
      vw[N*i +: N] = 32'hA0 + i;
    end
    vop(1, 32'h200, vw);
    repeat (4) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("reset_busy", V'(Busy), V'(0));
    for (int i = 0; i < BEATS; i++) begin
      sread(32'h200 + 4 * i);
      chk("reset_commit", V'(ReadData), V'(i < 4 ? 32'hA0 + i : 32'h5500 + i));
    end
    for (int c = 0; c < 600; c++) begin
      en = $urandom_range(0, 9) != 0;
      rst = $urandom_range(0, 99) == 0;
      n = $urandom_range(0, 15);
      VecWren = n == 0; VecRden = n == 1;
      WrenData = $urandom_range(0, 3) == 0; RdenData = $urandom_range(0, 2) == 0;
      AddressData = $urandom; ByteenaData = $urandom; WriteData = $urandom;
      VecWriteData = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step();
    end
    rst = 1'b0; en = 1'b1; RdenData = 1'b0; WrenData = 1'b0; VecRden = 1'b0; VecWren = 1'b0;
    repeat (12) step();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
